pll_reset_sequencer: RTL and testbench

Parametrised clock-domain supervisor for N Gowin rPLL instances, e.g. the fast SDRAM PLL plus the core PLL.
- Drives each PLL's RESET and qualifies the asynchronous lock outputs through synchronisers and a stability filter.
- Releases per-domain resets in a staggered order.
- Detects loss of lock, retries the PLLs after a timeout, and enters a fail state after too many retries.
- Runs on the free-running 27 MHz board clock, ahead of all PLL-derived logic.

---
 rtl/pll_seq_pkg.sv | 27 ++
 rtl/sync_2ff.sv | 21 ++
 rtl/pll_reset_sequencer.sv | 174 +++++++++++++++++
 tb/tb_pll_reset_sequencer.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pll_seq_pkg.sv
// Shared types and helpers for the PLL reset sequencer.
package pll_seq_pkg;

  typedef enum logic [2:0] {
    StPllRst,
    StWaitLock,
    StRelease,
    StRun,
    StFail
  } seq_state_e;

  localparam int unsigned SatW = 32;

  // Bits needed to hold values 0..max_val; never less than one bit.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

  // Increment that sticks at the all-ones value of a width-bit field.
  function automatic logic [SatW-1:0] sat_inc(input logic [SatW-1:0] val,
                                               input int unsigned width);
    logic [SatW-1:0] max_val;
    max_val = (width >= SatW) ? '1 : ((SatW'(1) << width) - SatW'(1));
    return (val >= max_val) ? val : val + SatW'(1);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchroniser, resets to 0.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_reset_sequencer.sv
// Supervises N PLLs: pulses their resets, qualifies lock, staggers domain reset release
// and retries or fails when lock never arrives.
module pll_reset_sequencer
  import pll_seq_pkg::*;
#(
  parameter int unsigned N_PLL               = 2,
  parameter int unsigned RESET_PULSE_CYCLES  = 32,
  parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 2700000,
  parameter int unsigned STAGGER_CYCLES      = 256,
  parameter int unsigned MAX_RETRIES         = 3,
  parameter int unsigned CNT_W               = 8
) (
  input  logic             clkin,
  input  logic             resetn,
  input  logic [N_PLL-1:0] pll_lock,
  input  logic             force_relock,
  input  logic             clear_status,
  output logic [N_PLL-1:0] pll_reset,
  output logic [N_PLL-1:0] domain_rstn,
  output logic             system_ready,
  output logic             fail,
  output logic             lock_lost,
  output logic [CNT_W-1:0] relock_count
);

  localparam int unsigned RstW = cnt_width(RESET_PULSE_CYCLES);
  localparam int unsigned StbW = cnt_width(LOCK_STABLE_CYCLES);
  localparam int unsigned ToW  = cnt_width(LOCK_TIMEOUT_CYCLES);
  localparam int unsigned RelW = cnt_width((N_PLL - 1) * STAGGER_CYCLES);
  localparam int unsigned RetW = cnt_width(MAX_RETRIES);

  seq_state_e      state;
  logic [RstW-1:0] rst_cnt;
  logic [StbW-1:0] stable_cnt;
  logic [ToW-1:0]  timeout_cnt;
  logic [RelW-1:0] rel_cnt;
  logic [RelW-1:0] rel_next;
  logic [RetW-1:0] retries;

  logic [N_PLL-1:0] lock_s;
  logic             all_locked;
  logic             relock_event;

  for (genvar g = 0; g < N_PLL; g++) begin : g_sync
    sync_2ff u_sync (
      .clk   (clkin),
      .rst_n (resetn),
      .d     (pll_lock[g]),
      .q     (lock_s[g])
    );
  end

  assign all_locked   = &lock_s;
  assign rel_next     = rel_cnt + 1'b1;
  assign relock_event = (state == StRun) && !all_locked;

  always_ff @(posedge clkin or negedge resetn) begin
    if (!resetn) begin
      state        <= StPllRst;
      rst_cnt      <= '0;
      stable_cnt   <= '0;
      timeout_cnt  <= '0;
      rel_cnt      <= '0;
      retries      <= '0;
      pll_reset    <= '1;
      domain_rstn  <= '0;
      system_ready <= 1'b0;
      fail         <= 1'b0;
    end else if (force_relock) begin
      state        <= StPllRst;
      rst_cnt      <= '0;
      stable_cnt   <= '0;
      timeout_cnt  <= '0;
      rel_cnt      <= '0;
      retries      <= '0;
      pll_reset    <= '1;
      domain_rstn  <= '0;
      system_ready <= 1'b0;
      fail         <= 1'b0;
    end else begin
      unique case (state)
        StPllRst: begin
          pll_reset   <= '1;
          domain_rstn <= '0;
          if (rst_cnt == RstW'(RESET_PULSE_CYCLES - 1)) begin
            state       <= StWaitLock;
            rst_cnt     <= '0;
            stable_cnt  <= '0;
            timeout_cnt <= '0;
            pll_reset   <= '0;
          end else begin
            rst_cnt <= rst_cnt + 1'b1;
          end
        end
        StWaitLock: begin
          // Stable lock takes priority over a timeout landing on the same cycle.
          if (all_locked && stable_cnt == StbW'(LOCK_STABLE_CYCLES - 1)) begin
            state          <= StRelease;
            rel_cnt        <= '0;
            domain_rstn    <= '0;
            domain_rstn[0] <= 1'b1;
          end else if (timeout_cnt == ToW'(LOCK_TIMEOUT_CYCLES - 1)) begin
            pll_reset <= '1;
            if (retries < RetW'(MAX_RETRIES)) begin
              retries <= retries + 1'b1;
              rst_cnt <= '0;
              state   <= StPllRst;
            end else begin
              fail  <= 1'b1;
              state <= StFail;
            end
          end else begin
            timeout_cnt <= timeout_cnt + 1'b1;
            stable_cnt  <= all_locked ? stable_cnt + 1'b1 : '0;
          end
        end
        StRelease: begin
          if (!all_locked) begin
            state       <= StPllRst;
            rst_cnt     <= '0;
            domain_rstn <= '0;
            pll_reset   <= '1;
          end else if (domain_rstn[N_PLL-1]) begin
            state        <= StRun;
            system_ready <= 1'b1;
            retries      <= '0;
          end else begin
            rel_cnt <= rel_next;
            for (int i = 1; i < N_PLL; i++) begin
              if (rel_next == RelW'(i * STAGGER_CYCLES)) domain_rstn[i] <= 1'b1;
            end
          end
        end
        StRun: begin
          retries <= '0;
          if (!all_locked) begin
            state        <= StPllRst;
            rst_cnt      <= '0;
            domain_rstn  <= '0;
            system_ready <= 1'b0;
            pll_reset    <= '1;
          end
        end
        StFail: begin
          fail        <= 1'b1;
          pll_reset   <= '1;
          domain_rstn <= '0;
        end
        default: begin
          state     <= StPllRst;
          rst_cnt   <= '0;
          pll_reset <= '1;
        end
      endcase
    end
  end

  // A relock event beats a simultaneous clear, leaving a count of one.
  always_ff @(posedge clkin or negedge resetn) begin
    if (!resetn) begin
      lock_lost    <= 1'b0;
      relock_count <= '0;
    end else if (relock_event) begin
      lock_lost    <= 1'b1;
      relock_count <= clear_status ? CNT_W'(1) :
                      CNT_W'(sat_inc(SatW'(relock_count), CNT_W));
    end else if (clear_status) begin
      lock_lost    <= 1'b0;
      relock_count <= '0;
    end
  end

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer with short timing parameters.
module tb_pll_reset_sequencer;

  localparam int unsigned N = 2;
  localparam int unsigned W = 4;

  logic         clkin = 1'b0;
  logic         resetn;
  logic [N-1:0] pll_lock;
  logic         force_relock;
  logic         clear_status;
  logic [N-1:0] pll_reset;
  logic [N-1:0] domain_rstn;
  logic         system_ready;
  logic         fail;
  logic         lock_lost;
  logic [W-1:0] relock_count;

  int n_checks = 0;
  int n_errors = 0;

  pll_reset_sequencer #(
    .N_PLL               (N),
    .RESET_PULSE_CYCLES  (4),
    .LOCK_STABLE_CYCLES  (16),
    .LOCK_TIMEOUT_CYCLES (100),
    .STAGGER_CYCLES      (8),
    .MAX_RETRIES         (2),
    .CNT_W               (W)
  ) dut (
    .clkin        (clkin),
    .resetn       (resetn),
    .pll_lock     (pll_lock),
    .force_relock (force_relock),
    .clear_status (clear_status),
    .pll_reset    (pll_reset),
    .domain_rstn  (domain_rstn),
    .system_ready (system_ready),
    .fail         (fail),
    .lock_lost    (lock_lost),
    .relock_count (relock_count)
  );

  always #5 clkin = ~clkin;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1);
  end

  task automatic step();
    @(posedge clkin);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Number of consecutive samples (starting now) with pll_reset asserted.
  task automatic pulse_len(output int n);
    n = 0;
    for (int i = 0; i < 50; i++) begin
      if (pll_reset == 2'b00) break;
      n++;
      step();
    end
  endtask

  // Steps until domain_rstn[0] (sel 0), domain_rstn[1] (sel 1) or system_ready (sel 2).
  task automatic wait_sig(input int sel, output int n, output int rst_seen);
    logic hit;
    n = -1;
    rst_seen = 0;
    for (int i = 0; i < 400; i++) begin
      hit = (sel == 0) ? domain_rstn[0] : (sel == 1) ? domain_rstn[1] : system_ready;
      if (hit) begin
        n = i;
        break;
      end
      if (pll_reset != 2'b00) rst_seen++;
      step();
    end
  endtask

  task automatic drop_and_relock(input int k);
    int n;
    int rs;
    pll_lock = 2'b10;
    step();
    step();
    if (k == 1) check("run_sync_latency_ready", system_ready, 1);
    step();
    if (k == 1) begin
      check("lol_domain_rstn", domain_rstn, 2'b00);
      check("lol_system_ready", system_ready, 0);
      check("lol_pll_reset", pll_reset, 2'b11);
      check("lol_lock_lost", lock_lost, 1);
    end
    check("lol_relock_count", relock_count, (k > 15) ? 15 : k);
    pll_lock = 2'b11;
    wait_sig(2, n, rs);
    check("lol_reready_cycles", n, 29);
  endtask

  initial begin
    int n;
    int rs;
    int rises;
    int high_total;
    int fail_idx;
    int starts[4];
    logic prev;

    resetn       = 1'b0;
    pll_lock     = 2'b00;
    force_relock = 1'b0;
    clear_status = 1'b0;
    repeat (3) step();
    check("rst_pll_reset", pll_reset, 2'b11);
    check("rst_domain_rstn", domain_rstn, 2'b00);
    check("rst_system_ready", system_ready, 0);
    check("rst_fail", fail, 0);
    check("rst_lock_lost", lock_lost, 0);
    check("rst_relock_count", relock_count, 0);

    // Clean bring-up
    resetn = 1'b1;
    pulse_len(n);
    check("t1_reset_pulse", n, 4);
    repeat (10) step();
    pll_lock = 2'b11;
    wait_sig(0, n, rs);
    check("t1_dom0_delay", n, 18);
    wait_sig(1, n, rs);
    check("t1_stagger", n, 8);
    wait_sig(2, n, rs);
    check("t1_ready_delay", n, 1);
    check("t1_domain_rstn", domain_rstn, 2'b11);
    check("t1_fail", fail, 0);

    // Glitch on lock[1] while the stable counter is at 10
    force_relock = 1'b1;
    pll_lock     = 2'b00;
    step();
    force_relock = 1'b0;
    check("t2_force_domain", domain_rstn, 2'b00);
    check("t2_force_ready", system_ready, 0);
    pulse_len(n);
    check("t2_reset_pulse", n, 4);
    repeat (10) step();
    pll_lock = 2'b11;
    repeat (10) step();
    pll_lock = 2'b01;
    step();
    pll_lock = 2'b11;
    wait_sig(0, n, rs);
    check("t2_dom0_after_glitch", n, 18);
    check("t2_no_pll_rst", rs, 0);
    wait_sig(1, n, rs);
    check("t2_stagger", n, 8);
    wait_sig(2, n, rs);
    check("t2_ready", n, 1);

    // Loss of lock in RUN, repeated until the counter saturates
    for (int k = 1; k <= 20; k++) drop_and_relock(k);
    check("t4_saturated", relock_count, 15);

    // clear_status coincident with a relock event, then alone
    pll_lock = 2'b10;
    step();
    step();
    clear_status = 1'b1;
    step();
    clear_status = 1'b0;
    check("t5_coinc_lock_lost", lock_lost, 1);
    check("t5_coinc_relock", relock_count, 1);
    pll_lock = 2'b11;
    wait_sig(2, n, rs);
    check("t5_reready", n, 29);
    clear_status = 1'b1;
    step();
    clear_status = 1'b0;
    check("t5_clear_lock_lost", lock_lost, 0);
    check("t5_clear_relock", relock_count, 0);
    check("t5_still_ready", system_ready, 1);

    // Never lock: three pulses then FAIL
    force_relock = 1'b1;
    pll_lock     = 2'b00;
    step();
    force_relock = 1'b0;
    rises      = 0;
    high_total = 0;
    fail_idx   = -1;
    prev       = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (fail) begin
        fail_idx = i;
        break;
      end
      if (pll_reset == 2'b11) begin
        high_total++;
        if (!prev) begin
          if (rises < 4) starts[rises] = i;
          rises++;
        end
      end
      prev = (pll_reset == 2'b11);
      step();
    end
    check("t3_pulse_count", rises, 3);
    check("t3_pulse_high_total", high_total, 12);
    check("t3_second_start", starts[1], 104);
    check("t3_third_start", starts[2], 208);
    check("t3_fail_cycle", fail_idx, 312);
    repeat (5) step();
    check("t3_fail_held", fail, 1);
    check("t3_fail_pll_reset", pll_reset, 2'b11);
    check("t3_fail_domain", domain_rstn, 2'b00);
    force_relock = 1'b1;
    step();
    force_relock = 1'b0;
    check("t3_force_clears_fail", fail, 0);
    pulse_len(n);
    check("t3_force_pulse", n, 4);

    // Async reset four cycles into RELEASE
    pll_lock = 2'b11;
    wait_sig(0, n, rs);
    check("t6_dom0_delay", n, 18);
    repeat (4) step();
    check("t6_mid_release_domain", domain_rstn, 2'b01);
    resetn = 1'b0;
    #1;
    check("t6_async_domain", domain_rstn, 2'b00);
    check("t6_async_pll_reset", pll_reset, 2'b11);
    check("t6_async_ready", system_ready, 0);
    step();
    step();
    resetn = 1'b1;
    pulse_len(n);
    check("t6_reset_pulse", n, 4);
    wait_sig(2, n, rs);
    check("t6_reready", n, 25);
    check("t6_domain_final", domain_rstn, 2'b11);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
